// File: rtl/fact_iter_if.sv
// Handshake bundle for the fact_iter block.
// The slave modport is the arithmetic block and the master modport is the
// producer/consumer pair driving it.
// The overflow flag out1 exists only when FACT_OVF_EN is defined.
interface fact_iter_if #(
  parameter int N = 16
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in0;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out0;
`ifdef FACT_OVF_EN
  logic         out1;
`endif

`ifdef FACT_OVF_EN
  modport master (
    output in_valid,
    output in0,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out0,
    input  out1
  );

  modport slave (
    input  in_valid,
    input  in0,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out0,
    output out1
  );
`else
  modport master (
    output in_valid,
    output in0,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out0
  );

  modport slave (
    input  in_valid,
    input  in0,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out0
  );
`endif

endinterface

// File: rtl/fact_iter.sv
// Iterative factorial / multi-factorial unit.
// STEP=1 computes n!, STEP=2 computes n!!, STEP=3 computes the triple
// factorial; the result is the low N bits of the product (wraps silently).
// Results can be retired and a new operand accepted on the same edge.
// Optional feature: define FACT_OVF_EN to add the sticky overflow flag out1,
// which reports whether any multiply of the operation lost upper bits.
module fact_iter #(
  parameter int N    = 16,
  parameter int STEP = 1
) (
  input  logic     clk,
  input  logic     nrst,
  fact_iter_if.slave bus
);

  localparam logic [N-1:0] STEP_N = N'(STEP);
  localparam logic [N-1:0] ONE_N  = N'(1);
  localparam logic [N-1:0] ZERO_N = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e       state_q;
  state_e       state_d;

  logic [N-1:0] acc_q;
  logic [N-1:0] acc_d;
  logic [N-1:0] cnt_q;
  logic [N-1:0] cnt_d;
  logic [N-1:0] out0_q;
  logic [N-1:0] out0_d;

  logic         inReady;
  logic         outValid;
  logic         accept;
  logic         cntMore;
  logic         mulStep;
  logic         finishStep;
  logic [N-1:0] prodLow;
  logic [N-1:0] cntStepped;

`ifdef FACT_OVF_EN
  logic [2*N-1:0] prodFull;
  logic           prodOvf;
  logic           ovfRun_q;
  logic           ovfRun_d;
  logic           out1_q;
  logic           out1_d;
`endif

  // Handshake qualifiers and the shared multiply; the counter value decides
  // between another multiply step and finishing.
  always_comb begin
    accept     = bus.in_valid & inReady;
    cntMore    = (cnt_q > ONE_N);
    mulStep    = (state_q == RUN) && cntMore;
    finishStep = (state_q == RUN) && !cntMore;
    cntStepped = (cnt_q > STEP_N) ? (cnt_q - STEP_N) : ZERO_N;
`ifdef FACT_OVF_EN
    prodFull   = {{N{1'b0}}, acc_q} * {{N{1'b0}}, cnt_q};
    prodLow    = prodFull[N-1:0];
    prodOvf    = |prodFull[2*N-1:N];
`else
    prodLow    = acc_q * cnt_q;
`endif
  end

  // State register; reset drops any operation in flight.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a held result leaves DONE only when the consumer takes it,
  // going straight back to RUN if a new operand is offered in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!cntMore) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = bus.in_valid ? RUN : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs; in DONE the input side is ready exactly when the result is taken.
  always_comb begin
    inReady  = 1'b0;
    outValid = 1'b0;
    unique case (state_q)
      IDLE: begin
        inReady  = 1'b1;
        outValid = 1'b0;
      end
      RUN: begin
        inReady  = 1'b0;
        outValid = 1'b0;
      end
      DONE: begin
        inReady  = bus.out_ready;
        outValid = 1'b1;
      end
      default: begin
        inReady  = 1'b0;
        outValid = 1'b0;
      end
    endcase
  end

  // Datapath next values: load on accept, multiply/decrement while running,
  // and capture the accumulator into out0 only on the step that enters DONE.
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    out0_d = out0_q;
    if (accept) begin
      acc_d = ONE_N;
      cnt_d = bus.in0;
    end else if (mulStep) begin
      acc_d = prodLow;
      cnt_d = cntStepped;
    end else if (finishStep) begin
      out0_d = acc_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc_q  <= ONE_N;
      cnt_q  <= ZERO_N;
      out0_q <= ZERO_N;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      out0_q <= out0_d;
    end
  end

`ifdef FACT_OVF_EN
  // Overflow tracking: sticky across one operation's multiplies, cleared on
  // accept, and published alongside out0 when the result is presented.
  always_comb begin
    ovfRun_d = ovfRun_q;
    out1_d   = out1_q;
    if (accept) begin
      ovfRun_d = 1'b0;
      out1_d   = 1'b0;
    end else if (mulStep) begin
      ovfRun_d = ovfRun_q | prodOvf;
    end else if (finishStep) begin
      out1_d = ovfRun_q;
    end
  end

  // Overflow registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ovfRun_q <= 1'b0;
      out1_q   <= 1'b0;
    end else begin
      ovfRun_q <= ovfRun_d;
      out1_q   <= out1_d;
    end
  end

  assign bus.out1 = out1_q;
`endif

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.out0      = out0_q;

endmodule

// File: tb/tb_fact_iter.sv
// Bench for fact_iter: one instance with STEP=1 and one with STEP=2 share the
// stimulus; a table of operands is run through them, followed by backpressure
// and mid-operation reset sequences. Results are checked by a scoreboard.
module tb_fact_iter;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         nrst = 1'b1;
  logic         sel;
  logic         inValid;
  logic [N-1:0] inData;
  logic         outReady;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [N-1:0] val;
    logic         ovf;
    int           n;
  } exp_t;

  exp_t sbQ[$];

  typedef struct {
    int step;
    int n;
    int expOut;
    bit expOvf;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  fact_iter_if #(.N(N)) bus1 ();
  fact_iter_if #(.N(N)) bus2 ();

  assign bus1.in_valid  = inValid & ~sel;
  assign bus2.in_valid  = inValid & sel;
  assign bus1.in0       = inData;
  assign bus2.in0       = inData;
  assign bus1.out_ready = outReady;
  assign bus2.out_ready = outReady;

  fact_iter #(.N(N), .STEP(1)) dut1 (.clk(clk), .nrst(nrst), .bus(bus1.slave));
  fact_iter #(.N(N), .STEP(2)) dut2 (.clk(clk), .nrst(nrst), .bus(bus2.slave));

  wire         curValid = sel ? bus2.out_valid : bus1.out_valid;
  wire         curReady = sel ? bus2.in_ready  : bus1.in_ready;
  wire [N-1:0] curOut   = sel ? bus2.out0      : bus1.out0;
`ifdef FACT_OVF_EN
  wire         curOvf   = sel ? bus2.out1      : bus1.out1;
`endif

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  function automatic int latModel(input int n, input int step);
    if (n >= 2) return ((n - 1) + step - 1) / step + 1;
    return 1;
  endfunction

  // Scoreboard: every retired result (out_valid & out_ready) is popped and compared.
  always @(negedge clk) begin
    if (nrst && curValid && outReady) begin
      if (sbQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected result: got out0=%0d, want no output", curOut);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput($sformatf("out0 n=%0d", e.n), curOut, e.val);
`ifdef FACT_OVF_EN
        checkOutput($sformatf("out1 n=%0d", e.n), curOvf, e.ovf);
`endif
      end
    end
  end

  // Offer one operand to the selected instance and push its expected result on accept.
  task automatic applyStimulus(input bit s, input int n, input int expOut, input bit expOvf,
                               output bit ok);
    int guard;
    exp_t e;
    sel     = s;
    inData  = N'(n);
    inValid = 1'b1;
    guard   = 0;
    #1;
    while (!curReady && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!curReady) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept timeout n=%0d: got in_ready=0, want 1", n);
      inValid = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge clk);
    e.val = N'(expOut);
    e.ovf = expOvf;
    e.n   = n;
    sbQ.push_back(e);
    #1;
    inValid = 1'b0;
    ok = 1'b1;
  endtask

  // Count edges from the accept edge to out_valid, then let the result retire.
  task automatic waitResult(input int expLat, input int n);
    int edges;
    edges = 0;
    while (edges < 300) begin
      @(posedge clk);
      #1;
      edges++;
      if (curValid) break;
    end
    checkOutput($sformatf("latency n=%0d", n), curValid ? edges : -1, expLat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    int guard;

    sel      = 1'b0;
    inValid  = 1'b0;
    inData   = '0;
    outReady = 1'b1;

    vecs[0]  = '{1, 8, 40320, 1'b0};
    vecs[1]  = '{1, 9, 35200, 1'b1};
    vecs[2]  = '{1, 0, 1, 1'b0};
    vecs[3]  = '{1, 1, 1, 1'b0};
    vecs[4]  = '{1, 2, 2, 1'b0};
    vecs[5]  = '{1, 12, 64512, 1'b1};
    vecs[6]  = '{1, 6, 720, 1'b0};
    vecs[7]  = '{2, 8, 384, 1'b0};
    vecs[8]  = '{2, 7, 105, 1'b0};
    vecs[9]  = '{2, 0, 1, 1'b0};
    vecs[10] = '{2, 3, 3, 1'b0};
    vecs[11] = '{2, 1, 1, 1'b0};

    // Reset state, observed while nrst is low and before any clock edge.
    #2;
    nrst = 1'b0;
    #1;
    checkOutput("reset out_valid dut1", bus1.out_valid, 0);
    checkOutput("reset out0 dut1", bus1.out0, 0);
    checkOutput("reset out_valid dut2", bus2.out_valid, 0);
    checkOutput("reset out0 dut2", bus2.out0, 0);
`ifdef FACT_OVF_EN
    checkOutput("reset out1 dut1", bus1.out1, 0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    #1;
    checkOutput("in_ready after reset dut1", bus1.in_ready, 1);
    checkOutput("in_ready after reset dut2", bus2.in_ready, 1);

    // Table-driven operands.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].step == 2, vecs[i].n, vecs[i].expOut, vecs[i].expOvf, ok);
      if (ok) waitResult(latModel(vecs[i].n, vecs[i].step), vecs[i].n);
    end

    // Backpressure: result held while out_ready is low, in_valid ignored.
    sel = 1'b0;
    outReady = 1'b0;
    applyStimulus(1'b0, 5, 120, 1'b0, ok);
    guard = 0;
    while (!curValid && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("backpressure out_valid", curValid, 1);
    inValid = 1'b1;
    inData  = N'(4);
    for (int i = 0; i < 10; i++) begin
      #1;
      checkOutput($sformatf("held out0 cycle %0d", i), curOut, 120);
      checkOutput($sformatf("held in_ready cycle %0d", i), curReady, 0);
      checkOutput($sformatf("held out_valid cycle %0d", i), curValid, 1);
      @(posedge clk);
      #1;
    end
    outReady = 1'b1;
    #1;
    checkOutput("retire+accept in_ready", curReady, 1);
    begin
      exp_t e;
      e.val = N'(24);
      e.ovf = 1'b0;
      e.n   = 4;
      sbQ.push_back(e);
    end
    @(posedge clk);
    #1;
    inValid = 1'b0;
    waitResult(latModel(4, 1), 4);

    // Reset in the middle of an operation discards it.
    applyStimulus(1'b0, 8, 40320, 1'b0, ok);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("mid-run out_valid before reset", curValid, 0);
    checkOutput("mid-run out0 before reset", curOut, 24);
    nrst = 1'b0;
    sbQ.delete();
    #1;
    checkOutput("mid-run reset out_valid", curValid, 0);
    checkOutput("mid-run reset out0", curOut, 0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    #1;
    checkOutput("in_ready after mid-run reset", curReady, 1);
    applyStimulus(1'b0, 6, 720, 1'b0, ok);
    if (ok) waitResult(latModel(6, 1), 6);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", sbQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
